// File: rtl/serial_pattern_tx_pkg.sv
// rtl/serial_pattern_tx_pkg.sv - traffic-controller serial defs shared by the pattern transmitter
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } tx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   ZO_CNT_W   = 8;

endpackage

// File: rtl/zo_transition_counter.sv
// rtl/zo_transition_counter.sv - saturating counter of 0->1 transitions on a qualified bit stream
module zo_transition_counter
    import serial_pattern_tx_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic [ZO_CNT_W-1:0] count
);

    logic                prev_q;
    logic [ZO_CNT_W-1:0] count_q;

    // prev starts at the idle level so the line's 1->0 into the first bit never counts
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_q  <= IDLE_LEVEL;
            count_q <= '0;
        end else if (bit_valid) begin
            if (!prev_q && bit_in && (count_q != '1)) begin
                count_q <= count_q + ZO_CNT_W'(1);
            end
            prev_q <= bit_in;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - shifts a programmable bit pattern out MSB-first, repeated, counting 0->1 edges
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [WIDTH-1:0]    pattern,
    input  logic [LEN_W-1:0]    len,
    input  logic [REP_W-1:0]    rep,
    output logic                ready,
    output logic                a,
    output logic                a_valid,
    output logic                done,
    output logic [ZO_CNT_W-1:0] zo_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [IDX_W-1:0] lm1_q, lm1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0] eff_lm1;
    logic             accept;

    // Zero or oversize length falls back to the full pattern width
    always_comb begin
        if ((len == '0) || (len > LEN_W'(WIDTH))) begin
            eff_lm1 = IDX_W'(WIDTH - 1);
        end else begin
            eff_lm1 = IDX_W'(len - LEN_W'(1));
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        lm1_d     = lm1_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        accept    = 1'b0;
        ready     = 1'b0;
        a         = IDLE_LEVEL;
        a_valid   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    accept    = 1'b1;
                    pattern_d = pattern;
                    lm1_d     = eff_lm1;
                    idx_d     = eff_lm1;
                    pass_d    = rep;
                    state_d   = SEND;
                end
            end
            SEND: begin
                a       = pattern_q[idx_q];
                a_valid = 1'b1;
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (pass_q != '0) begin
                    idx_d  = lm1_q;
                    pass_d = pass_q - REP_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            lm1_q     <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            lm1_q     <= lm1_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
        end
    end

    zo_transition_counter u_zo_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .bit_valid (a_valid),
        .bit_in    (a),
        .count     (zo_cnt)
    );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] rep;
    logic       ready;
    logic       a;
    logic       a_valid;
    logic       done;
    logic [7:0] zo_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    logic bits_q[$];
    int   zo_q[$];

    serial_pattern_tx dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .pattern (pattern),
        .len     (len),
        .rep     (rep),
        .ready   (ready),
        .a       (a),
        .a_valid (a_valid),
        .done    (done),
        .zo_cnt  (zo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Reference stream and transition count for one job
    task automatic push_job(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp);
        int   l;
        int   cnt;
        logic prev;
        logic pv;
        l    = ((ln == 0) || (ln > 8)) ? 8 : int'(ln);
        prev = 1'b1;
        cnt  = 0;
        pv   = 1'b0;
        for (int p = 0; p <= int'(rp); p++) begin
            for (int i = l - 1; i >= 0; i--) begin
                pv = pat[i];
                bits_q.push_back(pv);
                if (!prev && pv && cnt < 255) cnt++;
                prev = pv;
            end
        end
        zo_q.push_back(cnt);
    endtask

    // Drives load for one acceptance edge, returns at the negedge of cycle 1
    task automatic start_job(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp,
                             input bit hold);
        push_job(pat, ln, rp);
        pattern = pat;
        len     = ln;
        rep     = rp;
        load    = 1'b1;
        @(negedge clk);
        if (!hold) begin
            load    = 1'b0;
            pattern = ~pat;
            len     = ln + 4'd3;
            rep     = rp + 4'd2;
        end
    endtask

    task automatic wait_done(input int start_k, input int exp_k, input string tag);
        int k;
        k = start_k;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, k, exp_k);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (a_valid) begin
                check("bit_expected", 32'(bits_q.size() != 0), 1);
                if (bits_q.size() != 0) check("a_bit", a, bits_q.pop_front());
                check("ready_in_send", ready, 0);
            end
            if (done) begin
                n_done++;
                check("done_line_idle", {a_valid, a, ready}, 3'b010);
                check("done_expected", 32'(zo_q.size() != 0), 1);
                if (zo_q.size() != 0) check("zo_cnt_at_done", zo_cnt, zo_q.pop_front());
            end
        end
    end

    initial begin
        int d0;
        reset   = 1'b1;
        load    = 1'b0;
        pattern = 8'h00;
        len     = 4'd0;
        rep     = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {ready, a, a_valid, done}, 4'b1100);
        check("rst_zo", zo_cnt, 0);
        reset = 1'b0;

        // Reset in the middle of a job abandons it silently
        start_job(8'h55, 4'd0, 4'd3, 0);
        repeat (2) @(negedge clk);
        check("midjob_in_send", a_valid, 1);
        d0    = n_done;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bits_q.delete();
        zo_q.delete();
        check("midrst_outputs", {ready, a, a_valid, done}, 4'b1100);
        check("midrst_zo", zo_cnt, 0);
        @(negedge clk);
        check("midrst_no_done", n_done, d0);

        start_job(8'h05, 4'd4, 4'd0, 0);
        wait_done(1, 5, "t2_done_cycle");
        @(negedge clk);
        check("t2_ready", {ready, a, a_valid}, 3'b110);
        check("t2_zo", zo_cnt, 2);

        start_job(8'h0A, 4'd4, 4'd1, 0);
        wait_done(1, 9, "t3_done_cycle");
        @(negedge clk);
        check("t3_zo", zo_cnt, 3);

        start_job(8'h55, 4'd0, 4'd15, 0);
        wait_done(1, 129, "t4_done_cycle");
        @(negedge clk);
        check("t4_zo", zo_cnt, 64);

        // Loads while busy must be ignored
        start_job(8'h05, 4'd4, 4'd0, 0);
        load = 1'b1; pattern = 8'hFF; len = 4'd8; rep = 4'd5;
        @(negedge clk);
        load = 1'b1; pattern = 8'h3C; len = 4'd2; rep = 4'd7;
        @(negedge clk);
        load = 1'b0;
        wait_done(3, 5, "t5_done_cycle");
        @(negedge clk);
        check("t5_zo", zo_cnt, 2);
        check("t5_ready", ready, 1);

        // load held high: back-to-back jobs
        start_job(8'h05, 4'd4, 4'd0, 1);
        wait_done(1, 5, "t6a_done_cycle");
        push_job(8'h05, 4'd4, 4'd0);
        @(negedge clk);
        check("t6_ready_return", ready, 1);
        check("t6_zo_held", zo_cnt, 2);
        @(negedge clk);
        check("t6_reaccept", a_valid, 1);
        check("t6_zo_cleared", zo_cnt, 0);
        wait_done(1, 5, "t6b_done_cycle");
        @(negedge clk);
        load = 1'b0;
        check("t6_ready_end", ready, 1);
        @(negedge clk);
        check("t6_stays_idle", {ready, a_valid}, 2'b10);
        check("t6_zo_final", zo_cnt, 2);

        check("bits_drained", bits_q.size(), 0);
        check("zo_drained", zo_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
